// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory timeout, illegal-op trap, retire count.
// Optional UART_FUNCT_EN adds uart_tx (funct 0x39) and uart_rx (funct 0x3d).
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          OpCode,
  input  logic [5:0]          Funct,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [3:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                ExtOp,
  output logic                LuOp,
  output logic [3:0]          State,
  output logic                InstrDone,
  output logic [RETIRE_W-1:0] Retired,
  output logic                Illegal,
  output logic                BusError
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JREG   = 4'd12,
    TRAP   = 4'd15
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t state_q, state_n;
  logic [7:0] wcnt_q, wcnt_n;
  logic ill_q, ill_n, bus_q, bus_n;
  logic [RETIRE_W-1:0] ret_q;

  logic op_r, op_lw, op_sw, op_beq, op_j, op_jal;
  logic op_imm, op_andi, op_lui, op_slt;
  logic f_jr, f_jalr, f_shift, f_alu;
  logic f_utx, f_urx, f_exec;

  assign op_r    = OpCode == 6'h00;
  assign op_lw   = OpCode == 6'h23;
  assign op_sw   = OpCode == 6'h2b;
  assign op_beq  = OpCode == 6'h04;
  assign op_j    = OpCode == 6'h02;
  assign op_jal  = OpCode == 6'h03;
  assign op_andi = OpCode == 6'h0c;
  assign op_lui  = OpCode == 6'h0f;
  assign op_slt  = OpCode inside {6'h0a, 6'h0b};
  assign op_imm  = OpCode inside {6'h08, 6'h09, 6'h0a,
                                  6'h0b, 6'h0c, 6'h0f};

  assign f_jr    = Funct == 6'h08;
  assign f_jalr  = Funct == 6'h09;
  assign f_shift = Funct inside {6'h00, 6'h02, 6'h03};
  assign f_alu   = f_shift |
                   (Funct inside {[6'h20:6'h27], 6'h2a, 6'h2b});

`ifdef UART_FUNCT_EN
  assign f_utx = Funct == 6'h39;
  assign f_urx = Funct == 6'h3d;
`else
  assign f_utx = 1'b0;
  assign f_urx = 1'b0;
`endif

  assign f_exec = f_alu | f_utx | f_urx;

  // count register reaching the limit while still not ready traps
  logic mem_st, tmo;
  assign mem_st = state_q inside {FETCH, MEMRD, MEMWR};
  assign tmo    = mem_st & ~MemReady & (wcnt_q == TMO);
  assign wcnt_n = (mem_st & ~MemReady & ~tmo) ?
                  wcnt_q + 8'd1 : 8'd0;

  logic c_pcw, c_iord, c_mrd, c_mwr, c_irw, c_rgw;
  logic c_ext, c_lu, c_done, c_a3;
  logic [1:0] c_rdst, c_m2r, c_sa, c_sb, c_pcs;
  logic [2:0] c_aop;

  always_comb begin
    state_n = state_q;
    ill_n   = ill_q;
    bus_n   = bus_q;
    c_pcw   = 1'b0;
    c_iord  = 1'b0;
    c_mrd   = 1'b0;
    c_mwr   = 1'b0;
    c_irw   = 1'b0;
    c_rgw   = 1'b0;
    c_ext   = 1'b0;
    c_lu    = 1'b0;
    c_done  = 1'b0;
    c_rdst  = 2'b00;
    c_m2r   = 2'b00;
    c_sa    = 2'b00;
    c_sb    = 2'b00;
    c_pcs   = 2'b00;
    c_aop   = 3'b000;
    c_a3    = 1'b0;
    unique case (state_q)
      FETCH: begin
        c_mrd = 1'b1;
        c_sb  = 2'b01;
        c_irw = MemReady;
        c_pcw = MemReady;
        if (tmo) begin
          state_n = TRAP;
          bus_n   = 1'b1;
        end else if (MemReady) begin
          state_n = DECODE;
        end
      end
      DECODE: begin
        c_sb  = 2'b11;
        c_ext = ~op_andi;
        c_lu  = op_lui;
        unique case (1'b1)
          op_lw | op_sw:          state_n = MEMADR;
          op_r & (f_jr | f_jalr): state_n = JREG;
          op_r & f_exec:          state_n = EXEC;
          op_beq:                 state_n = BRANCH;
          op_j | op_jal:          state_n = JUMP;
          op_imm:                 state_n = IEXEC;
          default: begin
            state_n = TRAP;
            ill_n   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        c_sa    = 2'b01;
        c_sb    = 2'b10;
        c_ext   = ~op_andi;
        c_lu    = op_lui;
        state_n = op_lw ? MEMRD : MEMWR;
      end
      MEMRD: begin
        c_iord = 1'b1;
        c_mrd  = 1'b1;
        if (tmo) begin
          state_n = TRAP;
          bus_n   = 1'b1;
        end else if (MemReady) begin
          state_n = MEMWB;
        end
      end
      MEMWB: begin
        c_rgw   = 1'b1;
        c_m2r   = 2'b01;
        c_done  = 1'b1;
        state_n = FETCH;
      end
      MEMWR: begin
        c_iord = 1'b1;
        c_mwr  = 1'b1;
        c_done = MemReady;
        if (tmo) begin
          state_n = TRAP;
          bus_n   = 1'b1;
        end else if (MemReady) begin
          state_n = FETCH;
        end
      end
      EXEC: begin
        c_a3    = 1'b1;
        c_sa    = f_shift ? 2'b10 : 2'b01;
        c_aop   = 3'b010;
        state_n = ALUWB;
      end
      ALUWB: begin
        c_a3   = 1'b1;
        c_done = 1'b1;
        if (!f_utx) begin
          c_rgw  = 1'b1;
          c_rdst = 2'b01;
          c_m2r  = f_urx ? 2'b11 : 2'b00;
        end
        state_n = FETCH;
      end
      IEXEC: begin
        c_a3  = 1'b1;
        c_sa  = 2'b01;
        c_sb  = 2'b10;
        c_ext = ~op_andi;
        c_lu  = op_lui;
        c_aop = op_andi ? 3'b100 :
                op_slt  ? 3'b101 : 3'b000;
        state_n = IWB;
      end
      IWB: begin
        c_a3    = 1'b1;
        c_rgw   = 1'b1;
        c_done  = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        c_a3    = 1'b1;
        c_sa    = 2'b01;
        c_aop   = 3'b001;
        c_pcs   = 2'b01;
        c_pcw   = Zero;
        c_done  = 1'b1;
        state_n = FETCH;
      end
      JUMP: begin
        c_a3  = 1'b1;
        c_pcs = 2'b10;
        c_pcw = 1'b1;
        if (op_jal) begin
          c_rgw  = 1'b1;
          c_rdst = 2'b10;
          c_m2r  = 2'b10;
        end
        c_done  = 1'b1;
        state_n = FETCH;
      end
      JREG: begin
        c_a3  = 1'b1;
        c_pcs = 2'b11;
        c_pcw = 1'b1;
        if (f_jalr) begin
          c_rgw  = 1'b1;
          c_rdst = 2'b01;
          c_m2r  = 2'b10;
        end
        c_done  = 1'b1;
        state_n = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  // reset masks every strobe so an interrupted write never lands
  assign PCWrite   = c_pcw  & ~reset;
  assign IorD      = c_iord & ~reset;
  assign MemRead   = c_mrd  & ~reset;
  assign MemWrite  = c_mwr  & ~reset;
  assign IRWrite   = c_irw  & ~reset;
  assign RegWrite  = c_rgw  & ~reset;
  assign ExtOp     = c_ext  & ~reset;
  assign LuOp      = c_lu   & ~reset;
  assign InstrDone = c_done & ~reset;
  assign RegDst    = reset ? 2'b00 : c_rdst;
  assign MemtoReg  = reset ? 2'b00 : c_m2r;
  assign ALUSrcA   = reset ? 2'b00 : c_sa;
  assign ALUSrcB   = reset ? 2'b00 : c_sb;
  assign PCSrc     = reset ? 2'b00 : c_pcs;
  assign ALUOp     = reset ? 4'h0 :
                     {c_a3 & OpCode[0], c_aop};
  assign State     = state_q;
  assign Retired   = ret_q;
  assign Illegal   = ill_q;
  assign BusError  = bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wcnt_q  <= 8'd0;
      ill_q   <= 1'b0;
      bus_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_n;
      wcnt_q  <= wcnt_n;
      ill_q   <= ill_n;
      bus_q   <= bus_n;
      if (c_done)
        ret_q <= ret_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected bundles
// from an instruction-phase model, checked by an independent monitor.
module tb_multicycle_control;

  localparam int TMO = 15;
  localparam int RW  = 4;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_JREG   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd15;

`ifdef UART_FUNCT_EN
  localparam bit UART = 1'b1;
`else
  localparam bit UART = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]    st;
    logic          pcw, iord, mrd, mwr, irw, rgw;
    logic [1:0]    rdst, m2r, sa, sb;
    logic [3:0]    aop;
    logic [1:0]    pcs;
    logic          ext, lu, done, ill, bus;
    logic [RW-1:0] ret;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic Zero = 1'b0;
  logic MemReady = 1'b0;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0] ALUOp, State;
  logic ExtOp, LuOp, InstrDone, Illegal, BusError;
  logic [RW-1:0] Retired;

  multicycle_control #(.MEM_TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .ExtOp(ExtOp), .LuOp(LuOp),
    .State(State), .InstrDone(InstrDone), .Retired(Retired),
    .Illegal(Illegal), .BusError(BusError)
  );

  always #5 clk = ~clk;

  rec_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [5:0] cur_op, cur_f;
  logic [RW-1:0] exp_ret;
  logic exp_ill, exp_bus;

  always @(negedge clk) begin
    rec_t e, a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
           PCSrc, ExtOp, LuOp, InstrDone, Illegal, BusError,
           Retired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ctl cyc=%0d phase=%0d op=%h fn=%h got=%h want=%h",
                 cyc, e.st, cur_op, cur_f, a, e);
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic rec_t model(input logic [3:0] ph,
                                 input logic mr, input logic z);
    rec_t e;
    logic h;
    logic ext, lu;
    h   = cur_op[0];
    ext = (cur_op != 6'h0c);
    lu  = (cur_op == 6'h0f);
    e = '0;
    e.st  = ph;
    e.ill = exp_ill;
    e.bus = exp_bus;
    e.ret = exp_ret;
    case (ph)
      S_FETCH: begin
        e.mrd = 1; e.sb = 2'b01; e.irw = mr; e.pcw = mr;
      end
      S_DECODE: begin
        e.sb = 2'b11; e.ext = ext; e.lu = lu;
      end
      S_MEMADR: begin
        e.sa = 2'b01; e.sb = 2'b10; e.ext = ext; e.lu = lu;
      end
      S_MEMRD: begin
        e.iord = 1; e.mrd = 1;
      end
      S_MEMWB: begin
        e.rgw = 1; e.m2r = 2'b01; e.done = 1;
      end
      S_MEMWR: begin
        e.iord = 1; e.mwr = 1; e.done = mr;
      end
      S_EXEC: begin
        e.sa  = (cur_f inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
        e.aop = {h, 3'b010};
      end
      S_ALUWB: begin
        e.aop = {h, 3'b000}; e.done = 1;
        if (!(UART && cur_f == 6'h39)) begin
          e.rgw = 1; e.rdst = 2'b01;
          e.m2r = (UART && cur_f == 6'h3d) ? 2'b11 : 2'b00;
        end
      end
      S_IEXEC: begin
        e.sa = 2'b01; e.sb = 2'b10; e.ext = ext; e.lu = lu;
        if (cur_op == 6'h0c)
          e.aop = {h, 3'b100};
        else if (cur_op == 6'h0a || cur_op == 6'h0b)
          e.aop = {h, 3'b101};
        else
          e.aop = {h, 3'b000};
      end
      S_IWB: begin
        e.rgw = 1; e.aop = {h, 3'b000}; e.done = 1;
      end
      S_BRANCH: begin
        e.sa = 2'b01; e.aop = {h, 3'b001}; e.pcs = 2'b01;
        e.pcw = z; e.done = 1;
      end
      S_JUMP: begin
        e.pcs = 2'b10; e.pcw = 1; e.aop = {h, 3'b000}; e.done = 1;
        if (cur_op == 6'h03) begin
          e.rgw = 1; e.rdst = 2'b10; e.m2r = 2'b10;
        end
      end
      S_JREG: begin
        e.pcs = 2'b11; e.pcw = 1; e.aop = {h, 3'b000}; e.done = 1;
        if (cur_f == 6'h09) begin
          e.rgw = 1; e.rdst = 2'b01; e.m2r = 2'b10;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic stepz(input logic [3:0] ph, input logic mr,
                       input logic z);
    rec_t e;
    MemReady = mr;
    Zero = z;
    e = model(ph, mr, z);
    q.push_back(e);
    if (e.done) exp_ret = exp_ret + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] ph, input logic mr);
    stepz(ph, mr, rb());
  endtask

  task automatic rst_cycle(input logic [3:0] st);
    rec_t e;
    reset = 1'b1;
    MemReady = rb();
    Zero = rb();
    e = '0;
    e.st  = st;
    e.ret = exp_ret;
    e.ill = exp_ill;
    e.bus = exp_bus;
    q.push_back(e);
    @(posedge clk);
    #1;
    exp_ret = '0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] st);
    rst_cycle(st);
    rst_cycle(S_FETCH);
    reset = 1'b0;
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) step(S_TRAP, rb());
    do_reset(S_TRAP);
  endtask

  // w beyond TMO means memory never answers
  task automatic mem_wait(input logic [3:0] ph, input int w,
                          output bit trapped);
    trapped = 1'b0;
    if (w > TMO) begin
      for (int i = 0; i <= TMO; i++) step(ph, 1'b0);
      exp_bus = 1'b1;
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) step(ph, 1'b0);
      step(ph, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int wf, input int wm, input int zb);
    bit t;
    bit rexec;
    logic z;
    cur_op = op;
    cur_f  = f;
    OpCode = op;
    Funct  = f;
    z = (zb < 0) ? rb() : 1'(zb);
    rexec = (f inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27],
                       6'h2a, 6'h2b}) ||
            (UART && (f == 6'h39 || f == 6'h3d));
    mem_wait(S_FETCH, wf, t);
    if (t) begin
      trap_tail();
    end else begin
      step(S_DECODE, rb());
      if (op == 6'h23 || op == 6'h2b) begin
        step(S_MEMADR, rb());
        mem_wait(op == 6'h23 ? S_MEMRD : S_MEMWR, wm, t);
        if (t) trap_tail();
        else if (op == 6'h23) step(S_MEMWB, rb());
      end else if (op == 6'h00 && (f == 6'h08 || f == 6'h09)) begin
        step(S_JREG, rb());
      end else if (op == 6'h00 && rexec) begin
        step(S_EXEC, rb());
        step(S_ALUWB, rb());
      end else if (op == 6'h04) begin
        stepz(S_BRANCH, rb(), z);
      end else if (op == 6'h02 || op == 6'h03) begin
        step(S_JUMP, rb());
      end else if (op inside {6'h08, 6'h09, 6'h0a,
                              6'h0b, 6'h0c, 6'h0f}) begin
        step(S_IEXEC, rb());
        step(S_IWB, rb());
      end else begin
        exp_ill = 1'b1;
        trap_tail();
      end
    end
  endtask

  function automatic int rwait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 19) return int'($urandom_range(1, 4));
    return TMO;
  endfunction

  logic [5:0] ops[12] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03,
                          6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
  logic [5:0] fns[15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                          6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02,
                          6'h03, 6'h08, 6'h09};

  initial begin
    exp_ret = '0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    cur_op  = 6'h00;
    cur_f   = 6'h00;
    @(posedge clk);
    #1;
    do_reset(S_FETCH);

    run_instr(6'h00, 6'h20, 0, 0, -1);
    run_instr(6'h23, 6'h00, 0, 3, -1);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h03, 6'h00, 0, 0, -1);
    run_instr(6'h00, 6'h09, 0, 0, -1);
    run_instr(6'h2b, 6'h00, TMO, TMO, -1);
    run_instr(6'h23, 6'h00, TMO, TMO, -1);
    run_instr(6'h00, 6'h20, 100, 0, -1);
    run_instr(6'h23, 6'h00, 0, 100, -1);
    run_instr(6'h2b, 6'h00, 2, 100, -1);
    run_instr(6'h3f, 6'h00, 0, 0, -1);
    run_instr(6'h00, 6'h39, 0, 0, -1);
    run_instr(6'h00, 6'h3d, 0, 0, -1);
    run_instr(6'h00, 6'h01, 0, 0, -1);

    // reset lands while a store is waiting on memory
    cur_op = 6'h2b;
    OpCode = 6'h2b;
    step(S_FETCH, 1'b1);
    step(S_DECODE, rb());
    step(S_MEMADR, rb());
    step(S_MEMWR, 1'b0);
    do_reset(S_MEMWR);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, f;
      op = ops[$urandom_range(0, 11)];
      f  = fns[$urandom_range(0, 14)];
      run_instr(op, f, rwait(), rwait(), -1);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
